// File: rtl/spi_slave.sv
// ============================================================================
// spi_slave: serial command receiver and read-reply serializer in front of a
// single-port RAM.  Revision 1.0
// ============================================================================
`default_nettype none

module spi_slave (
  input  logic       MOSI,
  input  logic       SS_n,
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       MISO,
  output logic       rx_valid,
  output logic [9:0] rx_data
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  logic [2:0] state_q,    state_d;
  logic [3:0] bit_cnt_q,  bit_cnt_d;
  logic [8:0] shift_q,    shift_d;
  logic [9:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       miso_q,     miso_d;
  logic       rd_addr_q,  rd_addr_d;
  logic [3:0] tx_cnt_q,   tx_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [9:0] word;

  // Only nine bits are stored; the tenth completes the word straight from MOSI.
  assign word = {shift_q, MOSI};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    miso_d     = 1'b0;
    rd_addr_d  = rd_addr_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;

    case (state_q)
      IDLE: begin
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        bit_cnt_d = 4'd0;
        tx_cnt_d  = 4'd0;
        if (SS_n)          state_d = IDLE;
        else if (!MOSI)    state_d = WRITE;
        else if (rd_addr_q) state_d = READ_DATA;
        else               state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          state_d    = IDLE;
          bit_cnt_d  = 4'd0;
          tx_cnt_d   = 4'd0;
          shift_d    = 9'd0;
          rx_valid_d = 1'b0;
        end else if (bit_cnt_q != 4'd10) begin
          shift_d   = word[8:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            rx_data_d  = word;
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) rd_addr_d = 1'b1;
          end
        end else if (state_q == READ_DATA) begin
          // tx_cnt: 0 waiting for RAM, 1..7 shifting, 8 last-bit drop, 9 done
          if (tx_cnt_q == 4'd0) begin
            if (tx_valid) begin
              miso_d     = tx_data[7];
              tx_shift_d = {tx_data[6:0], 1'b0};
              tx_cnt_d   = 4'd1;
            end
          end else if (tx_cnt_q < 4'd8) begin
            miso_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            tx_cnt_d   = tx_cnt_q + 4'd1;
          end else if (tx_cnt_q == 4'd8) begin
            rd_addr_d = 1'b0;
            tx_cnt_d  = 4'd9;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 9'd0;
      rx_data_q  <= 10'd0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      rd_addr_q  <= 1'b0;
      tx_cnt_q   <= 4'd0;
      tx_shift_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      rd_addr_q  <= rd_addr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// tb_spi_slave: directed vector table for spi_slave plus async-reset checks.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       MOSI;
  logic       SS_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       MISO;
  logic       rx_valid;
  logic [9:0] rx_data;

  spi_slave dut (
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .MISO     (MISO),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss_n;
    logic       mosi;
    logic       txv;
    logic [7:0] txd;
    logic       e_miso;
    logic       e_rxv;
    logic [9:0] e_rxd;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] last_word;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic add(input logic ss, input logic mosi, input logic txv,
                     input logic [7:0] txd, input logic em, input logic ev,
                     input logic [9:0] ed);
    vec_t v;
    v.ss_n = ss; v.mosi = mosi; v.txv = txv; v.txd = txd;
    v.e_miso = em; v.e_rxv = ev; v.e_rxd = ed;
    vecs.push_back(v);
  endtask

  // IDLE -> CHK_CMD, then the command-select bit
  task automatic start_cmd(input logic sel);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, last_word);
    add(1'b0, sel,  1'b0, 8'h00, 1'b0, 1'b0, last_word);
  endtask

  task automatic add_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--)
      add(1'b0, w[i], 1'b0, 8'h00, 1'b0, (i == 0), (i == 0) ? w : last_word);
    last_word = w;
  endtask

  task automatic end_frame();
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, last_word);
  endtask

  task automatic check(input string name, input logic [11:0] got,
                       input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got miso=%b rx_valid=%b rx_data=%h, expected miso=%b rx_valid=%b rx_data=%h",
               name, got[11], got[10], got[9:0], exp[11], exp[10], exp[9:0]);
    end
  endtask

  initial begin
    logic [7:0] rb;
    last_word = 10'h000;

    // write address, then frame close
    start_cmd(1'b0);
    add_word(10'h0FA);
    end_frame();
    end_frame();
    // write data
    start_cmd(1'b0);
    add_word(10'h1AF);
    end_frame();
    // read address; rx_valid held one cycle after completion
    start_cmd(1'b1);
    add_word(10'h2C3);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h2C3);
    end_frame();
    // read data with 8-bit reply 0x6F
    start_cmd(1'b1);
    add_word(10'h333);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h333);
    add(1'b0, 1'b0, 1'b1, 8'h6F, 1'b0, 1'b1, 10'h333);
    rb = 8'h6F;
    for (int i = 6; i >= 0; i--)
      add(1'b0, 1'b0, 1'b0, 8'h00, rb[i], 1'b1, 10'h333);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h333);
    add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 10'h333);
    end_frame();
    // flag cleared: MOSI=1 must select READ_ADD, so tx_valid gets no reply
    start_cmd(1'b1);
    add_word(10'h2AA);
    add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 10'h2AA);
    end_frame();
    // abort a write after 5 bits, then a full word proves counters cleared
    start_cmd(1'b0);
    rb = 8'h0A;
    for (int i = 4; i >= 0; i--)
      add(1'b0, rb[i], 1'b0, 8'h00, 1'b0, 1'b0, last_word);
    end_frame();
    start_cmd(1'b0);
    add_word(10'h155);
    end_frame();
    // flag set by 0x2AA: reply started then abandoned by SS_n
    start_cmd(1'b1);
    add_word(10'h3C5);
    add(1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 10'h3C5);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h3C5);
    end_frame();
    // flag survived the abandon: still READ_DATA
    start_cmd(1'b1);
    add_word(10'h301);
    add(1'b0, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b1, 10'h301);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 10'h301);

    // reset state
    rst_n = 1'b1; SS_n = 1'b0; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {MISO, rx_valid, rx_data}, 12'h000);
    rst_n = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      SS_n     = vecs[k].ss_n;
      MOSI     = vecs[k].mosi;
      tx_valid = vecs[k].txv;
      tx_data  = vecs[k].txd;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), {MISO, rx_valid, rx_data},
            {vecs[k].e_miso, vecs[k].e_rxv, vecs[k].e_rxd});
    end

    // async reset mid-reply: outputs clear without a clock edge
    #2;
    rst_n = 1'b1;
    #1;
    check("async_reset", {MISO, rx_valid, rx_data}, 12'h000);
    @(posedge clk);
    #1;
    check("reset_hold", {MISO, rx_valid, rx_data}, 12'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave front-end for a single-port RAM.
- Receives 10-bit command words serially on MOSI (MSB first, one bit per clk rising edge while SS_n is low).
- Presents each word in parallel on rx_data with rx_valid to the RAM.
- For read-data commands, serializes the 8-bit RAM reply (tx_data and tx_valid) onto MISO.

Parameters:
- None. Word width 10 bits and reply width 8 bits are fixed.

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- rst_n  in  1  asynchronous reset, active-high (rst_n=1 resets, despite the name).
- MOSI  in  1  serial data from master.
- SS_n  in  1  slave select, active-low; framing.
- tx_valid  in  1  RAM read data valid.
- tx_data  in  8  RAM read data.
- MISO  out  1  serial data to master.
- rx_valid  out  1  rx_data holds a complete word.
- rx_data  out  10  received word: [9:8] command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- Positional port order: MOSI, SS_n, clk, rst_n, tx_valid, tx_data, MISO, rx_valid, rx_data.

Behaviour:
- Reset (async, rst_n=1):
  - State goes to IDLE.
  - MISO=0, rx_valid=0, rx_data=0.
  - Bit counters, shift registers and the rd_addr_received flag are cleared.
  - Reset mid-transfer aborts the transfer immediately.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD; otherwise stay.
- CHK_CMD:
  - SS_n=1 -> IDLE.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_received=0 -> READ_ADD.
  - MOSI=1 and rd_addr_received=1 -> READ_DATA.
  - This MOSI sample selects the state only; it is not part of the word.
- WRITE, READ_ADD, READ_DATA (receive phase):
  - Each rising edge shifts MOSI into a 10-bit shift register, MSB first, and increments the bit counter.
  - On the edge capturing the 10th bit, rx_data loads the complete word and rx_valid goes high.
  - rx_valid then stays high while in the state; it clears on the edge that returns to IDLE.
  - rx_data changes only on word completion; it holds its last value otherwise.
  - Bits beyond the 10th are ignored.
- Latency: first payload bit is sampled on the first edge in the state. rx_valid is high on the edge capturing bit 0 and one cycle after.
- Any of these states with SS_n=1 -> IDLE:
  - counters are cleared;
  - an incomplete word is discarded, with no rx_valid and no rx_data update.
- READ_ADD completion sets rd_addr_received=1.
- READ_DATA:
  - After the 10-bit word completes, the block waits for tx_valid.
  - On the first edge with tx_valid=1: latch tx_data, drive MISO=tx_data[7].
  - The next 7 edges drive bits 6..0.
  - After the 8th bit, MISO returns to 0 and rd_addr_received clears.
  - tx_valid is ignored before word completion, during shifting, and outside READ_DATA.
- MISO is 0 at all times except during the 8-bit reply.
- SS_n=1 during the reply -> IDLE, MISO=0, reply abandoned, rd_addr_received stays 1.
- Write commands (00/01) do not affect rd_addr_received.

Test Plan:
- Reset: rst_n=1 for one cycle -> MISO=0, rx_valid=0, rx_data=0.
- Write address:
  - Release reset with SS_n=0, MOSI=0; wait 2 cycles; shift 10'b00_1111_1010 -> one cycle later rx_data=0x0FA, rx_valid=1, MISO=0.
  - Raise SS_n -> rx_valid=0 within 2 cycles.
- Write data: SS_n=0, MOSI=0, 2 cycles, shift 10'b01_1010_1111 -> rx_data=0x1AF, rx_valid=1, MISO=0; SS_n=1 -> rx_valid=0.
- Read address: SS_n=0, MOSI=1 (flag clear -> READ_ADD), shift 10'b10_1100_0011 -> rx_data=0x2C3, rx_valid=1; SS_n=1 -> rx_valid=0, flag set.
- Read data:
  - SS_n=0, MOSI=1 (-> READ_DATA), shift 10'b11_0011_0011 -> rx_data=0x333, rx_valid=1, MISO=0.
  - Then tx_valid=1, tx_data=8'b0110_1111 -> MISO sequence 0,1,1,0,1,1,1,1 over 8 cycles, then 0; flag cleared.
  - Next MOSI=1 command -> READ_ADD.
- Abort: SS_n=1 after 5 bits in WRITE -> IDLE, rx_valid stays 0, rx_data unchanged. Async reset mid-reply -> MISO=0 immediately.
